// File: rtl/core_event_tracker_if.sv
// ---------------------------------------------------------------------------
// core_event_tracker_if
// Groups the per-instruction event stream of the core and the tracker's
// status outputs into one bundle.
//   master : the event producer (core / bench) drives the *_valid_i/*_id_i
//            events and observes the status.
//   slave  : the tracker consumes the events and drives the status.
// Events : dec/iss/wb/cmt/sq, each a valid bit plus an ID_W-bit id.
// Status : err_o (sticky), err_code_o, err_id_o, inflight_o, commit_cnt_o.
// ---------------------------------------------------------------------------
interface core_event_tracker_if #(
    parameter int NB_ID = 32
) ();
    localparam int ID_W = $clog2(NB_ID);

    logic            dec_valid_i;
    logic [ID_W-1:0] dec_id_i;
    logic            iss_valid_i;
    logic [ID_W-1:0] iss_id_i;
    logic            wb_valid_i;
    logic [ID_W-1:0] wb_id_i;
    logic            cmt_valid_i;
    logic [ID_W-1:0] cmt_id_i;
    logic            sq_valid_i;
    logic [ID_W-1:0] sq_id_i;

    logic            err_o;
    logic [2:0]      err_code_o;
    logic [ID_W-1:0] err_id_o;
    logic [ID_W:0]   inflight_o;
    logic [63:0]     commit_cnt_o;

    modport master (
        output dec_valid_i, dec_id_i, iss_valid_i, iss_id_i,
               wb_valid_i, wb_id_i, cmt_valid_i, cmt_id_i,
               sq_valid_i, sq_id_i,
        input  err_o, err_code_o, err_id_o, inflight_o, commit_cnt_o
    );

    modport slave (
        input  dec_valid_i, dec_id_i, iss_valid_i, iss_id_i,
               wb_valid_i, wb_id_i, cmt_valid_i, cmt_id_i,
               sq_valid_i, sq_id_i,
        output err_o, err_code_o, err_id_o, inflight_o, commit_cnt_o
    );
endinterface

// File: rtl/core_event_tracker.sv
// ---------------------------------------------------------------------------
// core_event_tracker
// In-order lifecycle checker for the core's instruction event stream. Keeps a
// circular window of NB_ID in-flight ids (FREE/DEC/ISS/WB per entry), checks
// every decode/issue/write-back/commit/squash against the entry's state at the
// start of the cycle, latches the first violation and counts legal commits.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   ev      : core_event_tracker_if.slave (events in, status out)
// All status outputs are registered; a cycle-N event shows up in cycle N+1.
// ---------------------------------------------------------------------------
module core_event_tracker #(
    parameter int NB_ID = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    core_event_tracker_if.slave  ev
);
    localparam int ID_W = $clog2(NB_ID);

    localparam logic [2:0] C_NONE      = 3'd0;
    localparam logic [2:0] C_DEC_ORDER = 3'd1;
    localparam logic [2:0] C_FULL      = 3'd2;
    localparam logic [2:0] C_ISS_STATE = 3'd3;
    localparam logic [2:0] C_WB_STATE  = 3'd4;
    localparam logic [2:0] C_CMT_ORDER = 3'd5;
    localparam logic [2:0] C_CMT_STATE = 3'd6;
    localparam logic [2:0] C_SQ_RANGE  = 3'd7;

    localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(NB_ID);

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_DEC  = 2'd1,
        ST_ISS  = 2'd2,
        ST_WB   = 2'd3
    } ent_state_e;

    ent_state_e      ent_q [NB_ID];
    ent_state_e      ent_d [NB_ID];
    logic [ID_W:0]   head_q, head_d;
    logic [ID_W:0]   tail_q, tail_d;
    logic [ID_W:0]   inflight_q, inflight_d;
    logic [63:0]     cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [2:0]      code_q, code_d;
    logic [ID_W-1:0] eid_q, eid_d;

    // Per-event legality, computed from start-of-cycle state.
    logic            cmt_legal, wb_legal, iss_legal, dec_legal, sq_legal;
    logic [2:0]      cmt_code, wb_code, iss_code, dec_code, sq_code;
    logic [ID_W:0]   head_nx, tail_nx, span, inflight_eff;
    logic [ID_W-1:0] sq_off;
    logic [NB_ID-1:0] sq_hit;

    always_comb begin
        cmt_legal = 1'b0;
        cmt_code  = C_NONE;
        if (ev.cmt_valid_i) begin
            if (ev.cmt_id_i != head_q[ID_W-1:0])      cmt_code  = C_CMT_ORDER;
            else if (ent_q[ev.cmt_id_i] != ST_WB)     cmt_code  = C_CMT_STATE;
            else                                      cmt_legal = 1'b1;
        end

        wb_legal = 1'b0;
        wb_code  = C_NONE;
        if (ev.wb_valid_i) begin
            if (ent_q[ev.wb_id_i] == ST_ISS) wb_legal = 1'b1;
            else                             wb_code  = C_WB_STATE;
        end

        iss_legal = 1'b0;
        iss_code  = C_NONE;
        if (ev.iss_valid_i) begin
            if (ent_q[ev.iss_id_i] == ST_DEC) iss_legal = 1'b1;
            else                              iss_code  = C_ISS_STATE;
        end

        head_nx = head_q + (ID_W+1)'(cmt_legal);

        // A commit in the same cycle frees a slot for the decode.
        inflight_eff = tail_q - head_q - (ID_W+1)'(cmt_legal);
        dec_legal = 1'b0;
        dec_code  = C_NONE;
        if (ev.dec_valid_i) begin
            if (inflight_eff == FULL_CNT)               dec_code  = C_FULL;
            else if (ev.dec_id_i != tail_q[ID_W-1:0])   dec_code  = C_DEC_ORDER;
            else                                        dec_legal = 1'b1;
        end
        tail_nx = tail_q + (ID_W+1)'(dec_legal);

        // Squash range is judged in offsets from the post-commit head, which
        // makes the wrapped window a plain unsigned compare.
        sq_off   = ev.sq_id_i - head_nx[ID_W-1:0];
        span     = tail_nx - head_nx;
        sq_legal = ev.sq_valid_i && ({1'b0, sq_off} < span);
        sq_code  = (ev.sq_valid_i && !sq_legal) ? C_SQ_RANGE : C_NONE;
    end

    // Entries at or beyond the squash point (up to tail'-1) are released.
    for (genvar gi = 0; gi < NB_ID; gi++) begin : g_sq
        logic [ID_W-1:0] ent_off;
        assign ent_off    = ID_W'(gi) - head_nx[ID_W-1:0];
        assign sq_hit[gi] = sq_legal
                         && ({1'b0, ent_off} >= {1'b0, sq_off})
                         && ({1'b0, ent_off} < span);
    end

    always_comb begin
        ent_d = ent_q;
        // Application order matters: commit, wb, issue, decode, then squash
        // overrides everything it covers.
        if (cmt_legal) ent_d[ev.cmt_id_i]       = ST_FREE;
        if (wb_legal)  ent_d[ev.wb_id_i]        = ST_WB;
        if (iss_legal) ent_d[ev.iss_id_i]       = ST_ISS;
        if (dec_legal) ent_d[tail_q[ID_W-1:0]]  = ST_DEC;
        for (int i = 0; i < NB_ID; i++) begin
            if (sq_hit[i]) ent_d[i] = ST_FREE;
        end

        head_d = head_nx;
        tail_d = sq_legal ? (head_nx + {1'b0, sq_off}) : tail_nx;
        inflight_d = tail_d - head_d;
        cnt_d  = cnt_q + 64'(cmt_legal);

        err_d  = err_q;
        code_d = code_q;
        eid_d  = eid_q;
        if (!err_q) begin
            // Lowest code wins among same-cycle violations.
            if (dec_code != C_NONE) begin
                err_d = 1'b1; code_d = dec_code; eid_d = ev.dec_id_i;
            end else if (iss_code != C_NONE) begin
                err_d = 1'b1; code_d = iss_code; eid_d = ev.iss_id_i;
            end else if (wb_code != C_NONE) begin
                err_d = 1'b1; code_d = wb_code;  eid_d = ev.wb_id_i;
            end else if (cmt_code != C_NONE) begin
                err_d = 1'b1; code_d = cmt_code; eid_d = ev.cmt_id_i;
            end else if (sq_code != C_NONE) begin
                err_d = 1'b1; code_d = sq_code;  eid_d = ev.sq_id_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NB_ID; i++) ent_q[i] <= ST_FREE;
            head_q     <= '0;
            tail_q     <= '0;
            inflight_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            code_q     <= C_NONE;
            eid_q      <= '0;
        end else begin
            ent_q      <= ent_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            code_q     <= code_d;
            eid_q      <= eid_d;
        end
    end

    assign ev.err_o        = err_q;
    assign ev.err_code_o   = code_q;
    assign ev.err_id_o     = eid_q;
    assign ev.inflight_o   = inflight_q;
    assign ev.commit_cnt_o = cnt_q;
endmodule

// File: tb/tb_core_event_tracker.sv
module tb_core_event_tracker;
    localparam int NB_ID = 32;

    logic clk;
    logic rst_n;
    int   n_err;
    int   n_checks;

    core_event_tracker_if #(.NB_ID(NB_ID)) ev ();

    core_event_tracker #(.NB_ID(NB_ID)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ev     (ev)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_ev();
        ev.dec_valid_i = 1'b0; ev.dec_id_i = '0;
        ev.iss_valid_i = 1'b0; ev.iss_id_i = '0;
        ev.wb_valid_i  = 1'b0; ev.wb_id_i  = '0;
        ev.cmt_valid_i = 1'b0; ev.cmt_id_i = '0;
        ev.sq_valid_i  = 1'b0; ev.sq_id_i  = '0;
    endtask

    // Apply the currently driven events for one clock, then idle the inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
        clear_ev();
    endtask

    task automatic do_reset();
        clear_ev();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic dec(input int id);
        ev.dec_valid_i = 1'b1; ev.dec_id_i = 5'(id); cyc();
    endtask
    task automatic iss(input int id);
        ev.iss_valid_i = 1'b1; ev.iss_id_i = 5'(id); cyc();
    endtask
    task automatic wb(input int id);
        ev.wb_valid_i = 1'b1; ev.wb_id_i = 5'(id); cyc();
    endtask
    task automatic cmt(input int id);
        ev.cmt_valid_i = 1'b1; ev.cmt_id_i = 5'(id); cyc();
    endtask

    initial begin
        n_err = 0;
        n_checks = 0;
        clear_ev();

        // Reset state
        do_reset();
        $display("step reset");
        chk("rst_err",      ev.err_o, 0);
        chk("rst_code",     ev.err_code_o, 0);
        chk("rst_eid",      ev.err_id_o, 0);
        chk("rst_inflight", ev.inflight_o, 0);
        chk("rst_cnt",      ev.commit_cnt_o, 0);

        // Three instructions through the full lifecycle, one event per cycle
        for (int i = 0; i < 3; i++) begin
            dec(i);
            chk("life_inflight_dec", ev.inflight_o, 1);
            iss(i);
            wb(i);
            cmt(i);
            $display("step life id=%0d cnt=%0d", i, ev.commit_cnt_o);
        end
        chk("life_cnt",      ev.commit_cnt_o, 3);
        chk("life_inflight", ev.inflight_o, 0);
        chk("life_err",      ev.err_o, 0);

        // Fill the window, then overflow it
        do_reset();
        for (int i = 0; i < 32; i++) dec(i);
        $display("step fill inflight=%0d", ev.inflight_o);
        chk("fill_inflight", ev.inflight_o, 32);
        chk("fill_err",      ev.err_o, 0);
        dec(0);
        chk("full_err",      ev.err_o, 1);
        chk("full_code",     ev.err_code_o, 2);
        chk("full_eid",      ev.err_id_o, 0);
        chk("full_inflight", ev.inflight_o, 32);

        // Same overflow decode, but with a legal commit of the head in the same cycle
        do_reset();
        for (int i = 0; i < 32; i++) dec(i);
        iss(0);
        wb(0);
        ev.cmt_valid_i = 1'b1; ev.cmt_id_i = 5'd0;
        ev.dec_valid_i = 1'b1; ev.dec_id_i = 5'd0;
        cyc();
        $display("step full+commit inflight=%0d", ev.inflight_o);
        chk("fullc_err",      ev.err_o, 0);
        chk("fullc_inflight", ev.inflight_o, 32);
        chk("fullc_cnt",      ev.commit_cnt_o, 1);

        // Squash from id 2 rewinds the tail to 2
        do_reset();
        for (int i = 0; i < 5; i++) dec(i);
        for (int i = 0; i < 5; i++) iss(i);
        ev.sq_valid_i = 1'b1; ev.sq_id_i = 5'd2;
        cyc();
        $display("step squash id=2 inflight=%0d", ev.inflight_o);
        chk("sq_inflight", ev.inflight_o, 2);
        chk("sq_err",      ev.err_o, 0);
        dec(5);
        chk("sq_dec5_code",     ev.err_code_o, 1);
        chk("sq_dec5_eid",      ev.err_id_o, 5);
        chk("sq_dec5_inflight", ev.inflight_o, 2);
        dec(2);
        chk("sq_dec2_inflight", ev.inflight_o, 3);

        // Out-of-order commit
        do_reset();
        dec(0); dec(1); iss(0); iss(1); wb(0); wb(1);
        cmt(1);
        $display("step commit id=1 out of order code=%0d", ev.err_code_o);
        chk("cmto_code",     ev.err_code_o, 5);
        chk("cmto_eid",      ev.err_id_o, 1);
        chk("cmto_cnt",      ev.commit_cnt_o, 0);
        chk("cmto_inflight", ev.inflight_o, 2);
        cmt(0);
        chk("cmto_cnt2",     ev.commit_cnt_o, 1);
        chk("cmto_inflight2", ev.inflight_o, 1);
        chk("cmto_code_kept", ev.err_code_o, 5);

        // Simultaneous violations: wb of a DEC id and issue of a FREE id
        do_reset();
        dec(0); dec(1);
        ev.wb_valid_i  = 1'b1; ev.wb_id_i  = 5'd0;
        ev.iss_valid_i = 1'b1; ev.iss_id_i = 5'd7;
        cyc();
        $display("step iss+wb violations code=%0d", ev.err_code_o);
        chk("multi_err",  ev.err_o, 1);
        chk("multi_code", ev.err_code_o, 3);
        chk("multi_eid",  ev.err_id_o, 7);

        // 100 instructions, pipelined so every stage is active each cycle
        do_reset();
        for (int k = 0; k < 103; k++) begin
            if (k < 100) begin
                ev.dec_valid_i = 1'b1; ev.dec_id_i = 5'(k % 32);
            end
            if (k >= 1 && k <= 100) begin
                ev.iss_valid_i = 1'b1; ev.iss_id_i = 5'((k - 1) % 32);
            end
            if (k >= 2 && k <= 101) begin
                ev.wb_valid_i = 1'b1; ev.wb_id_i = 5'((k - 2) % 32);
            end
            if (k >= 3) begin
                ev.cmt_valid_i = 1'b1; ev.cmt_id_i = 5'((k - 3) % 32);
            end
            cyc();
        end
        $display("step stream cnt=%0d", ev.commit_cnt_o);
        chk("stream_cnt",      ev.commit_cnt_o, 100);
        chk("stream_inflight", ev.inflight_o, 0);
        chk("stream_err",      ev.err_o, 0);
        dec(4); dec(5);
        chk("stream_tail_inflight", ev.inflight_o, 2);

        // Asynchronous reset mid-stream, away from any clock edge
        #3;
        rst_n = 1'b0;
        #1;
        $display("step async reset");
        chk("arst_inflight", ev.inflight_o, 0);
        chk("arst_cnt",      ev.commit_cnt_o, 0);
        chk("arst_err",      ev.err_o, 0);
        chk("arst_code",     ev.err_code_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dec(0);
        chk("post_rst_inflight", ev.inflight_o, 1);
        chk("post_rst_err",      ev.err_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/core_event_tracker.md
# core_event_tracker

Synthesizable in-order lifecycle checker that consumes the core's per-instruction event stream: decode, issue, write-back, commit and squash. It is the hardware receiving end of the same events the oracle monitor consumes. It keeps a circular window of in-flight instruction ids and checks that every event is legal for that id's current state. It reports the first protocol violation and exposes commit and occupancy counters. It sits beside the core pipeline, in parallel with the DPI monitor, and can be kept in FPGA builds where DPI is unavailable.

## Interface
- NB_ID, 32: window depth; must be a power of two; ids are `$clog2(NB_ID)` bits (ID_W) and wrap modulo NB_ID.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dec_valid_i / dec_id_i  in  1 / ID_W  decode event
- iss_valid_i / iss_id_i  in  1 / ID_W  issue event
- wb_valid_i / wb_id_i  in  1 / ID_W  write-back event
- cmt_valid_i / cmt_id_i  in  1 / ID_W  commit event
- sq_valid_i / sq_id_i  in  1 / ID_W  squash of sq_id_i and every younger in-flight id
- err_o  out  1  sticky: a violation has occurred
- err_code_o  out  3  code of the first violation: 0 none, 1 DEC_ORDER, 2 FULL, 3 ISS_STATE, 4 WB_STATE, 5 CMT_ORDER, 6 CMT_STATE, 7 SQ_RANGE
- err_id_o  out  ID_W  id carried by the first violating event
- inflight_o  out  ID_W+1  allocated entry count
- commit_cnt_o  out  64  legal commits since reset

## Operation
- Each entry holds a 2-bit state: FREE, DEC, ISS, WB.
- head and tail are (ID_W+1)-bit pointers with a wrap bit. inflight = tail − head.
- All checks use the state at the start of the cycle, except where noted. Events are applied in this order: commit, write-back, issue, decode, squash.
- **Commit**
  - cmt_id must equal head[ID_W-1:0], else CMT_ORDER.
  - The entry must be in WB, else CMT_STATE.
  - If legal: entry → FREE, head+1, commit_cnt+1.
- **Write-back:** the entry must be in ISS, else WB_STATE. If legal: → WB.
- **Issue:** the entry must be in DEC, else ISS_STATE. If legal: → DEC to ISS.
- **Decode**
  - Full check: if inflight minus a same-cycle legal commit equals NB_ID, flag FULL; checked first.
  - Order check: dec_id must equal tail[ID_W-1:0], else DEC_ORDER.
  - If legal: entry → DEC, tail+1.
- **Squash**
  - Valid range is [head', tail'), where head' is head after this cycle's commit and tail' is tail after this cycle's decode. A squash outside that range flags SQ_RANGE.
  - If legal: every entry from sq_id to tail'−1 → FREE, and tail ← position of sq_id (wrap bit chosen so head' ≤ tail ≤ tail').
  - A same-cycle issue, write-back or decode on a squashed id is overridden to FREE.
- **Illegal events** have no effect on state. Other legal events in the same cycle still apply.
- **Error latching:** only the first violation is latched into err_code_o/err_id_o. If several violations occur in one cycle, the lowest code wins. Later violations are ignored; err_o stays high until reset.
- Issue, write-back and commit events may target any id simultaneously, including the same id. The start-of-cycle-state rule makes issue+wb on the same id in one cycle a WB_STATE violation.

## Timing
- All outputs are registered. Every effect of a cycle-N event is visible on the outputs in cycle N+1.
- No backpressure: every event is consumed in the cycle it is valid.
- Reset (asynchronous assert, synchronous release): all entries FREE, head = tail = 0, err_o = 0, err_code_o = 0, err_id_o = 0, inflight_o = 0, commit_cnt_o = 0. A reset mid-operation discards all in-flight state immediately.
- Pointers wrap naturally. Full is tail − head = NB_ID; empty is head == tail.
- commit_cnt_o wraps at 2^64.

## Test plan
- Ids 0,1,2 each go through decode, issue, wb, commit in order, one event per cycle → commit_cnt_o = 3, inflight_o = 0, err_o = 0.
- Fill 32 decodes (ids 0–31), then decode id 0 → err_o = 1, err_code_o = 2, err_id_o = 0, inflight_o stays 32. Repeat with a legal commit of id 0 in the same cycle → no error, inflight_o = 32.
- Decode ids 0–4, issue 0–4, then squash id 2 → inflight_o = 2, tail = 2. The next decode must be id 2; a decode of id 5 gives DEC_ORDER.
- Id 0 in WB and id 1 in WB; commit id 1 first → err_code_o = 5, err_id_o = 1, commit_cnt_o unchanged. The following commit of id 0 is still counted.
- Write-back of a DEC-state id together with an issue of a FREE id in the same cycle → err_code_o = 3 (lowest code wins), err_id_o = the issue id.
- Run 100 instructions so the pointers wrap several times, then assert rst_ni low mid-stream → all outputs return to 0 immediately. Decode id 0 after release is accepted.
